// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC burst sequencer.
//   seq_state_t : sequencer FSM states
//   DEF_CODE_W  : default TDC code width
//   log2()      : ceil(log2(n)), used to size the accumulator and the mean shift
package tdc_pkg;

  localparam int DEF_CODE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_CAPTURE  = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } seq_state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_watchdog.sv
// Per-conversion watchdog for the TDC sequencer.
// Counts cycles while enabled. o_tc is high during the TIMEOUT-th enabled
// cycle after a clear, so the owner can abort on that same edge.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : restart the count (takes priority over enable)
//   i_enable       : count this cycle
//   o_tc           : terminal count reached in this cycle
module tdc_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WD_W'(1);
    end
  end

  assign o_tc = i_enable && (r_count == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/tdc_sequencer.sv
// Initiator side of the TDC controller start/ready handshake.
// A trigger launches a burst of N_AVG conversions; the codes are summed and
// the mean (sum >> log2(N_AVG), truncated) is offered on a valid/ack port.
// A watchdog aborts a conversion that does not reach ready in TIMEOUT cycles.
//   i_clk, i_rst_n   : clock, async active-low reset
//   i_trig           : burst request, only looked at in IDLE
//   o_busy           : trig accepted until back in IDLE
//   o_start          : one-cycle start pulse to the controller
//   i_clear/i_running: controller has acknowledged the start
//   i_ready, i_code  : conversion done, code valid
//   o_result, o_result_valid, i_result_ack : burst mean handshake
//   o_timeout_err    : sticky abort flag, cleared by the next accepted trig
//
// state      | meaning
// IDLE       | waiting for trig
// ARM        | start pulse out, watchdog restarted
// WAIT_ACK   | waiting for clear/running (or an early ready)
// WAIT_RDY   | conversion running, waiting for ready
// CAPTURE    | accumulate code, pick next conversion or finish
// DONE       | result offered until acked
// ERR        | watchdog expired, flag error and drop busy
module tdc_sequencer
  import tdc_pkg::*;
#(
  parameter int N_AVG   = 4,
  parameter int CODE_W  = DEF_CODE_W,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_trig,
  output logic              o_busy,
  output logic              o_start,
  input  logic              i_clear,
  input  logic              i_running,
  input  logic              i_ready,
  input  logic [CODE_W-1:0] i_code,
  output logic [CODE_W-1:0] o_result,
  output logic              o_result_valid,
  input  logic              i_result_ack,
  output logic              o_timeout_err
);

  localparam int LOG2_N = log2(N_AVG);
  localparam int SUM_W  = CODE_W + LOG2_N;
  localparam int IDX_W  = LOG2_N + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_AVG - 1);

  if ((N_AVG < 1) || ((N_AVG & (N_AVG - 1)) != 0)) begin : g_bad_navg
    $error("tdc_sequencer: N_AVG must be a power of 2 and >= 1");
  end
  if (TIMEOUT < 4) begin : g_bad_timeout
    $error("tdc_sequencer: TIMEOUT must be >= 4");
  end

  seq_state_t        r_state;
  logic              r_busy;
  logic              r_start;
  logic              r_result_valid;
  logic              r_timeout_err;
  logic [CODE_W-1:0] r_result;
  logic [CODE_W-1:0] r_code;
  logic [SUM_W-1:0]  r_sum;
  logic [IDX_W-1:0]  r_idx;

  logic              w_wd_clear;
  logic              w_wd_en;
  logic              w_wd_tc;
  logic [SUM_W-1:0]  w_sum_next;
  logic [CODE_W-1:0] w_mean;

  assign w_wd_clear = (r_state == S_ARM);
  assign w_wd_en    = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_RDY);
  assign w_sum_next = r_sum + SUM_W'(r_code);
  assign w_mean     = CODE_W'(w_sum_next >> LOG2_N);

  tdc_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_en),
    .o_tc     (w_wd_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_start        <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_result       <= '0;
      r_code         <= '0;
      r_sum          <= '0;
      r_idx          <= '0;
    end else begin
      // start is registered: it is raised on every entry to ARM and only there
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_trig) begin
            r_state       <= S_ARM;
            r_sum         <= '0;
            r_idx         <= '0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b1;
            r_start       <= 1'b1;
          end
        end
        S_ARM: begin
          r_state <= S_WAIT_ACK;
        end
        // ready beats the watchdog, and the watchdog beats clear/running so a
        // late acknowledge cannot carry the count past its terminal value
        S_WAIT_ACK: begin
          if (i_ready) begin
            r_code  <= i_code;
            r_state <= S_CAPTURE;
          end else if (w_wd_tc) begin
            r_state <= S_ERR;
          end else if (i_clear || i_running) begin
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (i_ready) begin
            r_code  <= i_code;
            r_state <= S_CAPTURE;
          end else if (w_wd_tc) begin
            r_state <= S_ERR;
          end
        end
        S_CAPTURE: begin
          r_sum <= w_sum_next;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            r_state        <= S_DONE;
            r_result_valid <= 1'b1;
            r_result       <= w_mean;
          end else begin
            r_state <= S_ARM;
            r_start <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_result_ack && r_result_valid) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        S_ERR: begin
          r_timeout_err <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_start        = r_start;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_tdc_sequencer.sv
module tb_tdc_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N_AVG=4 instance
  logic       trig4, busy4, start4, clear4, running4, ready4, rv4, ack4, terr4;
  logic [7:0] code4, res4;
  // N_AVG=1 instance
  logic       trig1, busy1, start1, clear1, running1, ready1, rv1, ack1, terr1;
  logic [7:0] code1, res1;

  tdc_sequencer #(.N_AVG(4), .CODE_W(8), .TIMEOUT(8)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig4), .o_busy(busy4), .o_start(start4),
    .i_clear(clear4), .i_running(running4), .i_ready(ready4), .i_code(code4),
    .o_result(res4), .o_result_valid(rv4), .i_result_ack(ack4), .o_timeout_err(terr4)
  );

  tdc_sequencer #(.N_AVG(1), .CODE_W(8), .TIMEOUT(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig1), .o_busy(busy1), .o_start(start1),
    .i_clear(clear1), .i_running(running1), .i_ready(ready1), .i_code(code1),
    .o_result(res1), .o_result_valid(rv1), .i_result_ack(ack1), .o_timeout_err(terr1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Controller model for dut4: start seen -> clear (cycle 1) -> running ->
  // one-cycle ready at cycle lat4 with the next code. lat4==0 never answers.
  int               lat4;
  logic [3:0][7:0]  codes4;
  int               c_cnt4 = -1;
  int               c_idx4 = 0;
  initial begin
    clear4 = 1'b0; running4 = 1'b0; ready4 = 1'b0; code4 = 8'd0;
    forever begin
      @(posedge clk); #1;
      ready4   = 1'b0;
      clear4   = 1'b0;
      running4 = 1'b0;
      if (!rst_n) c_cnt4 = -1;
      if (!busy4) c_idx4 = 0;
      if (c_cnt4 >= 0) begin
        c_cnt4++;
        clear4   = (c_cnt4 == 1) && (lat4 > 1);
        running4 = (c_cnt4 >= 2) && (c_cnt4 < lat4);
        if (c_cnt4 == lat4) begin
          ready4   = 1'b1;
          clear4   = 1'b0;
          running4 = 1'b0;
          code4    = codes4[c_idx4 % 4];
          c_idx4++;
          c_cnt4   = -1;
        end
      end
      if (start4 && (lat4 != 0)) c_cnt4 = 0;
    end
  end

  // Controller model for dut1: clear then ready two cycles after start.
  logic [7:0] code1v;
  int         c_cnt1 = -1;
  initial begin
    clear1 = 1'b0; running1 = 1'b0; ready1 = 1'b0; code1 = 8'd0;
    forever begin
      @(posedge clk); #1;
      ready1 = 1'b0;
      clear1 = 1'b0;
      if (!rst_n) c_cnt1 = -1;
      if (c_cnt1 >= 0) begin
        c_cnt1++;
        if (c_cnt1 == 1) clear1 = 1'b1;
        if (c_cnt1 == 2) begin
          ready1 = 1'b1;
          code1  = code1v;
          c_cnt1 = -1;
        end
      end
      if (start1) c_cnt1 = 0;
    end
  end

  typedef struct {
    int              lat;
    logic [3:0][7:0] c;
    int              exp_res;
    int              exp_err;
    int              exp_starts;
    int              exp_cyc;   // 0: latency not checked
  } vec_t;

  function automatic vec_t mk(input int lat, input int a, input int b, input int c, input int d,
                              input int res, input int err, input int starts, input int cyc);
    vec_t v;
    v.lat = lat;
    v.c[0] = 8'(a); v.c[1] = 8'(b); v.c[2] = 8'(c); v.c[3] = 8'(d);
    v.exp_res = res; v.exp_err = err; v.exp_starts = starts; v.exp_cyc = cyc;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t vecs [NV];
  int   one_codes [2];

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n_st, cyc, dbl, prev, bad, waited;

    vecs[0] = mk(2, 10, 12, 14, 16, 13, 0, 4, 0);
    vecs[1] = mk(2, 1, 1, 1, 2, 1, 0, 4, 0);
    vecs[2] = mk(1, 255, 255, 255, 255, 255, 0, 4, 0);
    vecs[3] = mk(8, 100, 0, 50, 3, 38, 0, 4, 0);     // ready on the watchdog terminal cycle
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 1, 1, 10);        // ready tied low
    vecs[5] = mk(3, 7, 8, 9, 10, 8, 0, 4, 0);        // also shows the error was cleared
    vecs[6] = mk(9, 5, 5, 5, 5, 0, 1, 1, 10);        // ready one cycle too late
    vecs[7] = mk(2, 200, 201, 202, 203, 201, 0, 4, 0);
    one_codes[0] = 255;
    one_codes[1] = 90;

    rst_n = 1'b0; trig4 = 1'b0; ack4 = 1'b0; trig1 = 1'b0; ack1 = 1'b0;
    lat4 = 2; codes4 = '0; code1v = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_busy", busy4, 0);
    chk("rst_start", start4, 0);
    chk("rst_valid", rv4, 0);
    chk("rst_err", terr4, 0);
    chk("rst_result", res4, 0);

    // table-driven bursts on the N_AVG=4 instance
    for (int v = 0; v < NV; v++) begin
      lat4   = vecs[v].lat;
      codes4 = vecs[v].c;
      @(posedge clk); #1; trig4 = 1'b1;
      @(posedge clk); #1; trig4 = 1'b0;
      chk($sformatf("v%0d_arm_busy", v), busy4, 1);
      chk($sformatf("v%0d_err_cleared", v), terr4, 0);
      n_st = 0; cyc = 0; dbl = 0; prev = 0;
      while (!rv4 && busy4 && cyc < 200) begin
        if (start4) begin
          n_st++;
          if (prev != 0) dbl = 1;
        end
        prev = start4;
        @(posedge clk); #1; cyc++;
      end
      chk($sformatf("v%0d_in_time", v), int'(cyc < 200), 1);
      chk($sformatf("v%0d_starts", v), n_st, vecs[v].exp_starts);
      chk($sformatf("v%0d_start_width", v), dbl, 0);
      chk($sformatf("v%0d_timeout_err", v), terr4, vecs[v].exp_err);
      chk($sformatf("v%0d_result_valid", v), rv4, 1 - vecs[v].exp_err);
      if (vecs[v].exp_cyc != 0) chk($sformatf("v%0d_abort_cycle", v), cyc, vecs[v].exp_cyc);
      if (vecs[v].exp_err == 0) begin
        chk($sformatf("v%0d_result", v), res4, vecs[v].exp_res);
        ack4 = 1'b1;
        @(posedge clk); #1; ack4 = 1'b0;
        chk($sformatf("v%0d_ack_busy", v), busy4, 0);
        chk($sformatf("v%0d_ack_valid", v), rv4, 0);
      end else begin
        bad = 0;
        repeat (4) begin
          @(posedge clk); #1;
          if (!terr4 || rv4 || busy4 || start4) bad++;
        end
        chk($sformatf("v%0d_err_sticky_idle", v), bad, 0);
      end
    end

    // reset in the middle of WAIT_RDY
    lat4 = 5; codes4 = '0;
    @(posedge clk); #1; trig4 = 1'b1;
    @(posedge clk); #1; trig4 = 1'b0;
    waited = 0;
    while (!running4 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    chk("rstmid_reached_wait", int'(running4), 1);
    chk("rstmid_busy_before", busy4, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_start", start4, 0);
    chk("rstmid_busy", busy4, 0);
    chk("rstmid_valid", rv4, 0);
    chk("rstmid_err", terr4, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy4 || start4 || rv4 || terr4) bad++;
    end
    chk("rstmid_idle_after", bad, 0);

    // back-pressure: trig and stray acks during the burst, ack held off in DONE
    lat4 = 2;
    codes4[0] = 8'd20; codes4[1] = 8'd30; codes4[2] = 8'd40; codes4[3] = 8'd50;
    @(posedge clk); #1; trig4 = 1'b1;
    @(posedge clk); #1;
    n_st = 0; cyc = 0;
    while (!rv4 && cyc < 200) begin
      if (start4) n_st++;
      trig4 = cyc[0];
      ack4  = (cyc % 3 == 1);
      @(posedge clk); #1; cyc++;
    end
    ack4 = 1'b0;
    chk("bp_in_time", int'(cyc < 200), 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      trig4 = i[0];
      @(posedge clk); #1;
      if (start4) n_st++;
      if (res4 != 8'd35 || !rv4 || !busy4 || start4) bad++;
    end
    chk("bp_result", res4, 35);
    chk("bp_held_stable", bad, 0);
    trig4 = 1'b1; ack4 = 1'b1;
    @(posedge clk); #1;
    trig4 = 1'b0; ack4 = 1'b0;
    chk("bp_ack_busy", busy4, 0);
    chk("bp_ack_valid", rv4, 0);
    repeat (6) begin
      @(posedge clk); #1;
      if (start4) n_st++;
    end
    chk("bp_total_starts", n_st, 4);
    chk("bp_stays_idle", busy4, 0);

    // N_AVG=1 passes the code straight through
    for (int k = 0; k < 2; k++) begin
      code1v = 8'(one_codes[k]);
      @(posedge clk); #1; trig1 = 1'b1;
      @(posedge clk); #1; trig1 = 1'b0;
      n_st = 0; cyc = 0;
      while (!rv1 && cyc < 100) begin
        if (start1) n_st++;
        @(posedge clk); #1; cyc++;
      end
      chk($sformatf("n1_%0d_in_time", k), int'(cyc < 100), 1);
      chk($sformatf("n1_%0d_result", k), res1, one_codes[k]);
      chk($sformatf("n1_%0d_starts", k), n_st, 1);
      chk($sformatf("n1_%0d_err", k), terr1, 0);
      ack1 = 1'b1;
      @(posedge clk); #1; ack1 = 1'b0;
      chk($sformatf("n1_%0d_idle", k), busy1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
